// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV64M multiply/divide unit for the execute stage.
// Computes MUL, DIV, DIVU, REM, REMU and their 32-bit W forms. Multiply is
// shift-add and division is restoring, one bit per cycle. Divide-by-zero and
// signed overflow are resolved at acceptance without iterating.
// Optional feature macro: MULDIV_FAST_MUL_EN. When defined, MUL/MULW is a
// single-cycle combinational multiply and the iterative MUL state is not built.
module muldiv_unit #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            valid_i,
    input  logic [2:0]      op_i,
    input  logic            word_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  logic            flush_i,
    output logic            ready_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);

`ifdef MULDIV_FAST_MUL_EN
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_DIV = 2'd2, ST_DONE = 2'd3} state_t;
`else
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_MUL = 2'd1, ST_DIV = 2'd2, ST_DONE = 2'd3} state_t;
`endif

    // Sign-extend a 32-bit value to 64 bits (W-form results).
    function automatic logic [63:0] sext32(input logic [31:0] x);
        return {{32{x[31]}}, x};
    endfunction

    state_t      state_r;
    logic [5:0]  cnt_r;        // completed iteration count
    logic        word_r;       // latched W flag
    logic        rem_op_r;     // latched: result is the remainder
    logic        neg_quo_r;    // quotient must be negated at the end
    logic        neg_rem_r;    // remainder must be negated at the end
    logic [63:0] rem_r;        // DIV: partial remainder; MUL: accumulator
    logic [63:0] quo_r;        // DIV: dividend/quotient shifter; MUL: multiplier
    logic [63:0] div_r;        // DIV: divisor magnitude; MUL: shifted multiplicand
    logic        done_r;
    logic [63:0] result_r;

    // Request decode and operand conditioning (W forms narrow to 32 bits).
    logic        is_mul_s;
    logic        sgn_s;
    logic        rem_op_s;
    logic [63:0] a_ext_s;
    logic [63:0] b_ext_s;
    logic [63:0] a_sx_s;
    logic        a_neg_s;
    logic        b_neg_s;
    logic [63:0] a_mag_s;
    logic [63:0] b_mag_s;
    logic [63:0] min_s;
    logic        div0_s;
    logic        ovf_s;
    logic [63:0] spec_res_s;

    assign is_mul_s = ~op_i[2];
    assign sgn_s    = ~op_i[0];
    assign rem_op_s = op_i[1];
    assign a_sx_s   = word_i ? sext32(a_i[31:0]) : a_i;
    assign a_ext_s  = word_i ? (sgn_s ? sext32(a_i[31:0]) : {32'd0, a_i[31:0]}) : a_i;
    assign b_ext_s  = word_i ? (sgn_s ? sext32(b_i[31:0]) : {32'd0, b_i[31:0]}) : b_i;
    assign a_neg_s  = sgn_s & a_ext_s[63];
    assign b_neg_s  = sgn_s & b_ext_s[63];
    assign a_mag_s  = a_neg_s ? (64'd0 - a_ext_s) : a_ext_s;
    assign b_mag_s  = b_neg_s ? (64'd0 - b_ext_s) : b_ext_s;
    assign min_s    = word_i ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000;
    assign div0_s   = (b_ext_s == 64'd0);
    assign ovf_s    = sgn_s & (a_ext_s == min_s) & (b_ext_s == {64{1'b1}});
    // Divide-by-zero: q = all ones, r = dividend; overflow: q = dividend, r = 0.
    assign spec_res_s = div0_s ? (rem_op_s ? a_sx_s : {64{1'b1}})
                               : (rem_op_s ? 64'd0 : a_sx_s);

    // One restoring-division step: shift in next dividend bit, trial-subtract.
    logic [64:0] shifted_s;
    logic [64:0] trial_s;
    logic        fits_s;
    logic [63:0] rem_nx_s;
    logic [63:0] quo_nx_s;
    logic [63:0] div_q_s;
    logic [63:0] div_m_s;
    logic [63:0] div_sel_s;
    logic [63:0] div_res_s;
    logic        last_s;

    assign shifted_s = {rem_r, quo_r[63]};
    assign trial_s   = shifted_s - {1'b0, div_r};
    assign fits_s    = ~trial_s[64];
    assign rem_nx_s  = fits_s ? trial_s[63:0] : shifted_s[63:0];
    assign quo_nx_s  = {quo_r[62:0], fits_s};
    assign div_q_s   = neg_quo_r ? (64'd0 - quo_nx_s) : quo_nx_s;
    assign div_m_s   = neg_rem_r ? (64'd0 - rem_nx_s) : rem_nx_s;
    assign div_sel_s = rem_op_r ? div_m_s : div_q_s;
    assign div_res_s = word_r ? sext32(div_sel_s[31:0]) : div_sel_s;
    assign last_s    = (cnt_r == (word_r ? 6'd31 : 6'd63));

`ifdef MULDIV_FAST_MUL_EN
    logic [63:0] prod_s;
    logic [63:0] fast_res_s;
    assign prod_s     = a_i * b_i;
    assign fast_res_s = word_i ? sext32(prod_s[31:0]) : prod_s;
`else
    // One shift-add multiply step; only the low 64 product bits are kept.
    logic [63:0] acc_nx_s;
    logic [63:0] mul_res_s;
    assign acc_nx_s  = rem_r + (quo_r[0] ? div_r : 64'd0);
    assign mul_res_s = word_r ? sext32(acc_nx_s[31:0]) : acc_nx_s;
`endif

    assign ready_o  = (state_r == ST_IDLE) & ~flush_i;
    assign done_o   = done_r;
    assign result_o = result_r;

    // Control FSM, iteration datapath and registered result/done.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            cnt_r     <= 6'd0;
            word_r    <= 1'b0;
            rem_op_r  <= 1'b0;
            neg_quo_r <= 1'b0;
            neg_rem_r <= 1'b0;
            rem_r     <= 64'd0;
            quo_r     <= 64'd0;
            div_r     <= 64'd0;
            done_r    <= 1'b0;
            result_r  <= 64'd0;
        end else if (flush_i) begin
            state_r <= ST_IDLE;
            done_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (valid_i) begin
                        cnt_r    <= 6'd0;
                        word_r   <= word_i;
                        rem_op_r <= rem_op_s;
                        if (is_mul_s) begin
`ifdef MULDIV_FAST_MUL_EN
                            result_r <= fast_res_s;
                            done_r   <= 1'b1;
                            state_r  <= ST_DONE;
`else
                            rem_r   <= 64'd0;
                            div_r   <= a_i;
                            quo_r   <= b_i;
                            state_r <= ST_MUL;
`endif
                        end else if (div0_s || ovf_s) begin
                            result_r <= spec_res_s;
                            done_r   <= 1'b1;
                            state_r  <= ST_DONE;
                        end else begin
                            rem_r     <= 64'd0;
                            div_r     <= b_mag_s;
                            quo_r     <= word_i ? {a_mag_s[31:0], 32'd0} : a_mag_s;
                            neg_quo_r <= a_neg_s ^ b_neg_s;
                            neg_rem_r <= a_neg_s;
                            state_r   <= ST_DIV;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
`ifndef MULDIV_FAST_MUL_EN
                ST_MUL: begin
                    rem_r <= acc_nx_s;
                    div_r <= {div_r[62:0], 1'b0};
                    quo_r <= {1'b0, quo_r[63:1]};
                    cnt_r <= cnt_r + 6'd1;
                    if (last_s) begin
                        result_r <= mul_res_s;
                        done_r   <= 1'b1;
                        state_r  <= ST_DONE;
                    end else begin
                        state_r <= ST_MUL;
                    end
                end
`endif
                ST_DIV: begin
                    rem_r <= rem_nx_s;
                    quo_r <= quo_nx_s;
                    cnt_r <= cnt_r + 6'd1;
                    if (last_s) begin
                        result_r <= div_res_s;
                        done_r   <= 1'b1;
                        state_r  <= ST_DONE;
                    end else begin
                        state_r <= ST_DIV;
                    end
                end
                ST_DONE: begin
                    done_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    done_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed plus randomized self-checking bench for muldiv_unit.
// Results come from an arithmetic reference model of the RV64M rules; latency
// follows the iteration-count rules (honours MULDIV_FAST_MUL_EN when defined).
module tb_muldiv_unit;

    logic        clk;
    logic        reset;
    logic        valid_i;
    logic [2:0]  op_i;
    logic        word_i;
    logic [63:0] a_i;
    logic [63:0] b_i;
    logic        flush_i;
    logic        ready_o;
    logic        done_o;
    logic [63:0] result_o;

    int checks;
    int errors;

    muldiv_unit dut (
        .clk      (clk),
        .reset    (reset),
        .valid_i  (valid_i),
        .op_i     (op_i),
        .word_i   (word_i),
        .a_i      (a_i),
        .b_i      (b_i),
        .flush_i  (flush_i),
        .ready_o  (ready_o),
        .done_o   (done_o),
        .result_o (result_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // RV64M semantics with plain integer arithmetic.
    function automatic logic [63:0] ref_model(input logic [2:0] op, input logic w,
                                              input logic [63:0] a, input logic [63:0] b);
        longint          sa, sb;
        longint unsigned ua, ub;
        int              sa32, sb32;
        int unsigned     ua32, ub32;
        logic [31:0]     r32;
        logic [63:0]     r;
        if (!op[2]) begin
            r = a * b;
            if (w) r = {{32{r[31]}}, r[31:0]};
            return r;
        end
        if (w) begin
            sa32 = int'(a[31:0]);  sb32 = int'(b[31:0]);
            ua32 = a[31:0];        ub32 = b[31:0];
            case (op[1:0])
                2'b00: if (ub32 == 0) r32 = 32'hFFFF_FFFF;
                       else if (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF) r32 = a[31:0];
                       else r32 = 32'(sa32 / sb32);
                2'b01: if (ub32 == 0) r32 = 32'hFFFF_FFFF; else r32 = ua32 / ub32;
                2'b10: if (ub32 == 0) r32 = a[31:0];
                       else if (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF) r32 = 32'd0;
                       else r32 = 32'(sa32 % sb32);
                default: if (ub32 == 0) r32 = a[31:0]; else r32 = ua32 % ub32;
            endcase
            return {{32{r32[31]}}, r32};
        end
        sa = longint'(a); sb = longint'(b); ua = a; ub = b;
        case (op[1:0])
            2'b00: if (ub == 0) r = {64{1'b1}};
                   else if (a == 64'h8000_0000_0000_0000 && b == {64{1'b1}}) r = a;
                   else r = 64'(sa / sb);
            2'b01: if (ub == 0) r = {64{1'b1}}; else r = ua / ub;
            2'b10: if (ub == 0) r = a;
                   else if (a == 64'h8000_0000_0000_0000 && b == {64{1'b1}}) r = 64'd0;
                   else r = 64'(sa % sb);
            default: if (ub == 0) r = a; else r = ua % ub;
        endcase
        return r;
    endfunction

    // Cycle (after acceptance) in which done_o is expected.
    function automatic int ref_latency(input logic [2:0] op, input logic w,
                                       input logic [63:0] a, input logic [63:0] b);
        int n;
        n = w ? 32 : 64;
        if (!op[2]) begin
`ifdef MULDIV_FAST_MUL_EN
            return 1;
`else
            return n + 1;
`endif
        end
        if (w ? (b[31:0] == 32'd0) : (b == 64'd0)) return 1;
        if (!op[0] && (w ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
                         : (a == 64'h8000_0000_0000_0000 && b == {64{1'b1}}))) return 1;
        return n + 1;
    endfunction

    // Issue one request (called just after a negedge) and check it to completion.
    task automatic run_op(input string tag, input logic [2:0] op, input logic w,
                          input logic [63:0] a, input logic [63:0] b);
        logic [63:0] exp_res;
        logic [63:0] prev;
        int          exp_cyc;
        int          cyc;
        bit          seen;
        bit          rdy_bad;
        bit          res_moved;
        exp_res = ref_model(op, w, a, b);
        exp_cyc = ref_latency(op, w, a, b);
        check({tag, " ready_before"}, 64'(ready_o), 64'd1);
        prev = result_o;
        valid_i = 1'b1; op_i = op; word_i = w; a_i = a; b_i = b;
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        op_i = 3'($urandom); word_i = 1'($urandom);
        a_i = {$urandom(), $urandom()}; b_i = {$urandom(), $urandom()};
        seen = 1'b0; cyc = 0; rdy_bad = 1'b0; res_moved = 1'b0;
        while (!seen && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (ready_o) rdy_bad = 1'b1;
            if (done_o) seen = 1'b1;
            else if (result_o !== prev) res_moved = 1'b1;
        end
        check({tag, " done_seen"}, 64'(seen), 64'd1);
        check({tag, " latency"}, 64'(cyc), 64'(exp_cyc));
        check({tag, " result"}, result_o, exp_res);
        check({tag, " ready_low_busy"}, 64'(rdy_bad), 64'd0);
        check({tag, " result_held_busy"}, 64'(res_moved), 64'd0);
        @(negedge clk);
        check({tag, " done_one_cycle"}, 64'(done_o), 64'd0);
        check({tag, " ready_after"}, 64'(ready_o), 64'd1);
        check({tag, " result_stable"}, result_o, exp_res);
    endtask

    initial begin
        logic [63:0] prev;
        logic [63:0] a;
        logic [63:0] b;
        logic [2:0]  op;
        logic        w;
        bit          saw_done;
        checks = 0; errors = 0;
        reset = 1'b1; valid_i = 1'b0; op_i = 3'd0; word_i = 1'b0;
        a_i = 64'd0; b_i = 64'd0; flush_i = 1'b0;
        repeat (2) @(negedge clk);
        check("reset ready", 64'(ready_o), 64'd1);
        check("reset done", 64'(done_o), 64'd0);
        check("reset result", result_o, 64'd0);
        reset = 1'b0;
        @(negedge clk);

        // Directed cases from the test plan.
        run_op("mul 3*-2", 3'b000, 1'b0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFE);
        run_op("div -7/2", 3'b100, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2);
        run_op("rem -7%2", 3'b110, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2);
        run_op("divu 100/7", 3'b101, 1'b0, 64'd100, 64'd7);
        run_op("remu 100%7", 3'b111, 1'b0, 64'd100, 64'd7);
        run_op("divu by0", 3'b101, 1'b0, 64'h1234, 64'd0);
        run_op("remu by0", 3'b111, 1'b0, 64'h1234, 64'd0);
        run_op("div ovf", 3'b100, 1'b0, 64'h8000_0000_0000_0000, {64{1'b1}});
        run_op("rem ovf", 3'b110, 1'b0, 64'h8000_0000_0000_0000, {64{1'b1}});
        run_op("divuw", 3'b101, 1'b1, 64'hFFFF_FFFF_0000_0010, 64'd3);
        run_op("mulw", 3'b000, 1'b1, 64'h7FFF_FFFF, 64'd2);
        run_op("divw ovf", 3'b100, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF);
        run_op("mul reserved op", 3'b011, 1'b0, 64'd12345, 64'd678);

        // Flush in cycle 10 of a DIV, then a DIVU accepted in cycle 11.
        prev = result_o;
        valid_i = 1'b1; op_i = 3'b100; word_i = 1'b0; a_i = 64'd1000; b_i = 64'd7;
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        saw_done = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            if (done_o) saw_done = 1'b1;
        end
        @(negedge clk);
        if (done_o) saw_done = 1'b1;
        flush_i = 1'b1;
        @(posedge clk);
        #1;
        flush_i = 1'b0;
        @(negedge clk);
        if (done_o) saw_done = 1'b1;
        check("flush ready_c11", 64'(ready_o), 64'd1);
        check("flush no_done", 64'(saw_done), 64'd0);
        check("flush result_kept", result_o, prev);
        run_op("divu 9/3 after flush", 3'b101, 1'b0, 64'd9, 64'd3);

        // flush_i together with valid_i in IDLE must not accept.
        valid_i = 1'b1; flush_i = 1'b1; op_i = 3'b101; a_i = 64'd10; b_i = 64'd2;
        @(posedge clk);
        #1;
        valid_i = 1'b0; flush_i = 1'b0;
        @(negedge clk);
        check("flush+valid ready", 64'(ready_o), 64'd1);
        check("flush+valid done", 64'(done_o), 64'd0);

        // Async reset in cycle 20 of a DIV.
        valid_i = 1'b1; op_i = 3'b100; word_i = 1'b0; a_i = 64'd99999; b_i = 64'd13;
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        repeat (19) @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("midreset ready", 64'(ready_o), 64'd1);
        check("midreset done", 64'(done_o), 64'd0);
        check("midreset result", result_o, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        saw_done = 1'b0;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            if (done_o) saw_done = 1'b1;
        end
        check("midreset no_stale_done", 64'(saw_done), 64'd0);

        // Randomized requests, biased toward the special divisor values.
        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 7));
            w  = 1'($urandom_range(0, 1));
            a  = {$urandom(), $urandom()};
            if ($urandom_range(0, 3) == 0) a = 64'($urandom_range(0, 200));
            case ($urandom_range(0, 4))
                0: b = 64'd0;
                1: b = {64{1'b1}};
                2: b = 64'($urandom_range(1, 15));
                3: b = {$urandom(), 32'd0};
                default: b = {$urandom(), $urandom()};
            endcase
            if ($urandom_range(0, 7) == 0) a = w ? {$urandom(), 32'h8000_0000} : 64'h8000_0000_0000_0000;
            run_op($sformatf("rand%0d op%0d w%0d", i, op, w), op, w, a, b);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Iterative RV64M multiply/divide unit for the execute stage. It computes MUL, DIV, DIVU, REM and REMU, plus their 32-bit W forms. Its registered 64-bit result is one of the candidate inputs to the 8-way result/writeback select mux. The core stalls on ready_o and captures result_o on the done_o pulse.

Parameters:
XLEN, 64, datapath width; only 64 is supported.

Ports:
clk  in  1  clock; all state updates on the rising edge
reset  in  1  asynchronous, active-high reset
valid_i  in  1  request valid; sampled only when ready_o=1
op_i  in  3  000 MUL, 100 DIV, 101 DIVU, 110 REM, 111 REMU; 001/010/011 are reserved and treated as MUL
word_i  in  1  1 = W variant (operate on bits [31:0], sign-extend the 32-bit result)
a_i  in  64  dividend / multiplicand (rs1)
b_i  in  64  divisor / multiplier (rs2)
flush_i  in  1  abort any in-flight operation
ready_o  out  1  1 when idle and able to accept a request
done_o  out  1  one-cycle pulse: result_o is valid
result_o  out  64  registered result

Behaviour:
- Reset: state IDLE, ready_o=1, done_o=0, result_o=0, all iteration registers 0. Reset asserted mid-operation discards the operation; no done_o follows.
- States: IDLE, MUL, DIV, DONE.
- ready_o = (state==IDLE) && !flush_i.
- Acceptance: valid_i && ready_o at a clock edge; call that cycle 0. Operands and op are latched; a_i, b_i and op_i may change afterwards.
- Iteration count N = 64, or 32 when word_i=1.
- MUL: shift-add, one multiplier bit per cycle, during cycles 1..N.
  - Only the low 64 bits are produced; signedness is irrelevant.
  - W form: low 32 bits of the product, sign-extended.
- DIV/DIVU/REM/REMU: restoring division, one quotient bit per cycle, during cycles 1..N.
  - Signed ops divide absolute values.
  - Quotient is negated if operand signs differ.
  - Remainder takes the dividend's sign.
  - W form uses 32-bit operands, sign-extended for DIVW/REMW and zero-extended for DIVUW/REMUW; the 32-bit result is always sign-extended.
- Special cases, detected at acceptance, skip iteration and go straight to DONE (done_o in cycle 1):
  - Divide by zero: quotient = all ones; remainder = dividend (W: dividend[31:0] sign-extended).
  - Signed overflow (most-negative / -1): quotient = dividend; remainder = 0.
  - W overflow quotient = 0xFFFFFFFF80000000.
- Normal latency: done_o high in cycle N+1 (65 or 33); state returns to IDLE in cycle N+2.
- ready_o is low in cycles 1..N+1, so back-to-back requests are accepted no earlier than cycle N+2.
- result_o is loaded on entry to DONE and held stable until the next DONE entry. It does not change on acceptance, flush or idle.
- flush_i=1 in any state: next state IDLE, done_o=0 next cycle, result_o unchanged.
  - flush_i in DONE suppresses nothing already visible: done_o was asserted that cycle; the next cycle is IDLE.
  - flush_i with valid_i in IDLE: no acceptance.
- Operand registers are not cleared on flush. A new acceptance reloads them fully.

Optional Feature:
MULDIV_FAST_MUL_EN:
- Defined: MUL/MULW computed by a single-cycle combinational multiply registered into result_o; path IDLE->DONE, done_o in cycle 1. The MUL state is not built.
- Undefined: iterative multiply as specified above (done_o in cycle 65/33).
- Division is unaffected either way.

Test Plan:
- MUL a=3, b=0xFFFFFFFFFFFFFFFE -> result_o=0xFFFFFFFFFFFFFFFA with done_o in cycle 65 (cycle 1 with MULDIV_FAST_MUL_EN); ready_o low cycles 1..65.
- DIV a=-7, b=2 -> 0xFFFFFFFFFFFFFFFD in cycle 65; REM same operands -> 0xFFFFFFFFFFFFFFFF; DIVU a=100, b=7 -> 14; REMU -> 2.
- DIVU a=0x1234, b=0 -> 0xFFFFFFFFFFFFFFFF in cycle 1; REMU -> 0x1234. DIV a=0x8000000000000000, b=-1 -> 0x8000000000000000; REM -> 0.
- Word ops:
  - DIVUW a=0xFFFFFFFF00000010, b=3 -> 5 in cycle 33.
  - MULW a=0x7FFFFFFF, b=2 -> 0xFFFFFFFFFFFFFFFE.
  - DIVW a=0x80000000, b=0xFFFFFFFF -> 0xFFFFFFFF80000000 in cycle 1.
- DIV accepted in cycle 0, flush_i in cycle 10:
  - no done_o ever; ready_o=1 in cycle 11; result_o keeps its prior value.
  - A new DIVU 9/3 accepted in cycle 11 yields 3 in cycle 76.
- reset pulsed in cycle 20 of a DIV: ready_o=1, done_o=0, result_o=0 immediately; no stale done_o afterwards.
